// File: rtl/oddr_serializer_if.sv
// Parallel word handshake into the DDR output serializer.
// Lane l occupies in_data[l*RATIO +: RATIO].
interface oddr_serializer_if #(
  parameter int WIDTH = 1,
  parameter int RATIO = 4
);
  logic [WIDTH*RATIO-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/oddr_serializer.sv
// Multi-lane DDR serializer: RATIO-bit words become D1/D2 pairs per cycle.
// Optional ODDR_SERIALIZER_TRAINING_EN adds a train port (1/0 idle pattern).
module oddr_serializer #(
  parameter int WIDTH     = 1,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0,
  parameter bit IDLE      = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
`ifdef ODDR_SERIALIZER_TRAINING_EN
  input  logic             train,
`endif
  oddr_serializer_if.slave up,
  output logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] D2,
  output logic             busy,
  output logic             underrun
);

  localparam int PAIRS = RATIO / 2;
  localparam int NB    = WIDTH * RATIO;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

  typedef logic [NB-1:0]    word_t;
  typedef logic [WIDTH-1:0] lane_t;

  // sel=0 picks the rising-phase bit of pair k, sel=1 the falling one
  function automatic lane_t pick(input word_t w, input int k,
                                 input bit sel);
    lane_t o;
    int    p;
    o = '0;
    for (int l = 0; l < WIDTH; l++) begin
      if (MSB_FIRST != 0)
        p = RATIO - 1 - 2 * k - int'(sel);
      else
        p = 2 * k + int'(sel);
      o[l] = w[l*RATIO+p];
    end
    return o;
  endfunction

  logic          active;
  logic [CW-1:0] cnt;
  word_t         sh;
  word_t         hold;
  logic          hold_full;
  logic          last;
  logic          gate;
  logic          ready;
  logic          accept;
  lane_t         idle1;
  lane_t         idle2;

`ifdef ODDR_SERIALIZER_TRAINING_EN
  assign idle1 = train ? '1 : {WIDTH{IDLE}};
  assign idle2 = train ? '0 : {WIDTH{IDLE}};
  assign gate  = !train;
`else
  assign idle1 = {WIDTH{IDLE}};
  assign idle2 = {WIDTH{IDLE}};
  assign gate  = 1'b1;
`endif

  assign last   = (cnt == LAST);
  assign ready  = CE & !R & gate
                & (!hold_full | (active & last));
  assign accept = up.in_valid & ready;

  assign up.in_ready = ready;
  assign busy        = active | hold_full;

  always_ff @(posedge C) begin
    if (R) begin
      active    <= 1'b0;
      cnt       <= '0;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      D1        <= {WIDTH{IDLE}};
      D2        <= {WIDTH{IDLE}};
      underrun  <= 1'b0;
    end else if (CE) begin
      underrun <= 1'b0;
      if (!active) begin
        if (accept) begin
          sh     <= up.in_data;
          active <= 1'b1;
          cnt    <= '0;
          D1     <= pick(up.in_data, 0, 1'b0);
          D2     <= pick(up.in_data, 0, 1'b1);
        end else begin
          D1 <= idle1;
          D2 <= idle2;
        end
      end else if (!last) begin
        cnt <= cnt + 1'b1;
        D1  <= pick(sh, int'(cnt) + 1, 1'b0);
        D2  <= pick(sh, int'(cnt) + 1, 1'b1);
        if (accept) begin
          hold      <= up.in_data;
          hold_full <= 1'b1;
        end
      end else if (hold_full) begin
        sh        <= hold;
        cnt       <= '0;
        D1        <= pick(hold, 0, 1'b0);
        D2        <= pick(hold, 0, 1'b1);
        hold_full <= accept;
        if (accept)
          hold <= up.in_data;
      end else if (accept) begin
        // no gap: next word goes straight into the shifter
        sh  <= up.in_data;
        cnt <= '0;
        D1  <= pick(up.in_data, 0, 1'b0);
        D2  <= pick(up.in_data, 0, 1'b1);
      end else begin
        active   <= 1'b0;
        D1       <= idle1;
        D2       <= idle2;
        underrun <= 1'b1;
      end
    end else begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: doc/oddr_serializer.md
# oddr_serializer

Parametrised multi-lane DDR output serializer. It accepts RATIO-bit parallel words per lane through a valid/ready handshake and streams them as per-cycle rising/falling bit pairs (D1/D2) that feed an ODDRWrapper in SAME_EDGE mode. It sits between the fabric-side transmit datapath and the pin-level DDR primitives. A one-word hold buffer keeps output gapless under continuous input.

## Interface
Parameters:
- WIDTH, 1, number of lanes.
- RATIO, 4, bits per lane per word; even, 2..16.
- MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit RATIO-1 sent first.
- IDLE, 0, 1-bit level driven on D1 and D2 of every lane when no word is being sent.

Ports:
- C  in  1  clock; all state updates on posedge C.
- R  in  1  reset; synchronous, active-high; overrides CE.
- CE  in  1  clock enable; when low, all state frozen.
- in_data  in  WIDTH*RATIO  lane l uses in_data[l*RATIO +: RATIO].
- in_valid  in  1  word offered.
- in_ready  out  1  word accepted on an edge where in_valid & in_ready.
- D1  out  WIDTH  rising-phase bit per lane (registered).
- D2  out  WIDTH  falling-phase bit per lane (registered).
- busy  out  1  shifter active or hold word pending.
- underrun  out  1  one-cycle pulse; stream ended without a following word.

## Operation
- PAIRS = RATIO/2. Each word occupies PAIRS output cycles.
- State: shifter (WIDTH*RATIO bits, active flag, pair counter 0..PAIRS-1), hold register (data, full flag).
- LSB-first pair k: D1 = bit 2k, D2 = bit 2k+1. MSB-first pair k: D1 = bit RATIO-1-2k, D2 = bit RATIO-2-2k. Mapping is applied per lane.
- in_ready = CE & !R & (!hold_full | (active & cnt==PAIRS-1)). This is combinational from registers only.
- Transitions on a CE-high edge:
  - IDLE (!active): on accept, load the word into the shifter and output pair 0; set cnt=0 and active=1.
  - Shifting, cnt<PAIRS-1: output pair cnt+1 and increment cnt. On accept, write the word to hold.
  - Last pair (cnt==PAIRS-1):
    - If hold is full: move hold to the shifter, output pair 0, cnt=0. A simultaneous accept refills hold.
    - Else if accepting: load the incoming word directly into the shifter.
    - Else: active=0, D1/D2 = IDLE, pulse underrun.
- RATIO=2: every word is on its last pair, so continuous valid sustains one word per cycle.
- busy = active | hold_full.

## Timing
- Reset values: D1 = D2 = {WIDTH{IDLE}}; in_ready = 0 while R is high; busy = 0; underrun = 0; hold empty; shifter inactive; cnt = 0.
- Latency: a word accepted at edge t from idle appears as pair 0 on D1/D2 after edge t. Pair k appears after edge t+k.
- Back-to-back words produce no idle cycle between the last pair of word N and pair 0 of word N+1.
- Reset mid-word: the word and hold contents are discarded. Outputs are IDLE after the reset edge with no underrun pulse.
- CE low: D1/D2, counters and hold are held; in_ready = 0; underrun = 0.
- underrun is high for exactly the cycle after the edge that returns the shifter to idle.

## Configuration
- ODDR_SERIALIZER_TRAINING_EN defined:
  - Adds input port train (1 bit).
  - While train=1 and the shifter is inactive, every lane drives D1=1, D2=0 (a forwarded-clock pattern) instead of IDLE.
  - in_ready is forced to 0 while train=1. A word in progress completes first.
- Not defined: the port is absent and the idle level is always IDLE.

## Test plan
- Reset: R=1 for 3 cycles with in_valid=1 -> in_ready=0, D1=D2=IDLE, busy=0. After release, the first accept occurs on the next edge.
- WIDTH=2, RATIO=4, LSB-first, single word in_data=8'hA5:
  - Two cycles of D1=2'b01, D2=2'b10.
  - Then D1=D2=IDLE and underrun pulses once.
- Same config, MSB_FIRST=1, words 8'h1E then 8'hC3 offered back-to-back:
  - Four consecutive pair cycles with no gap.
  - Lane0 pairs (D1,D2) are (1,1),(1,0) for word 1, then (0,0),(1,1) for word 2.
  - Exactly one underrun, after word 2.
- RATIO=2, in_valid held high for 8 words -> in_ready stays 1 throughout, one word is output per cycle, and no underrun occurs until valid drops.
- Reset asserted on pair 1 of a RATIO=8 word while hold is full -> outputs IDLE after that edge, busy=0, no underrun, and the hold word is never emitted.
- CE low for 3 cycles mid-word -> D1/D2 unchanged and in_ready=0. The remaining pairs resume on re-enable, each appearing exactly once.
